// File: rtl/scan_capture.sv
// scan_capture
// Receive side of a row/column LED-matrix scan. It samples the scanned row
// and column buses, waits for each row to be stable before accepting it, and
// rebuilds a full gs x gs frame. Completed frames go to a consumer over a
// valid/ready handshake.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   row_val_i      one-hot row select (bit r = row r), all-zero = blank
//   col_val_i      column data of the selected row (bit c = pixel (r,c))
//   e_cap_i        capture enable
//   frame_ready_i  consumer ready
//   matrix_o       captured frame, bit r*gs+c = pixel (r,c)
//   frame_valid_o  matrix_o holds a frame the consumer has not taken yet
//   err_o          one-cycle pulse on a scan protocol violation
//   overrun_o      one-cycle pulse when a completed frame had to be dropped
module scan_capture #(
  parameter int gs = 8,
  parameter int st = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [gs-1:0]      row_val_i,
  input  logic [gs-1:0]      col_val_i,
  input  logic               e_cap_i,
  input  logic               frame_ready_i,
  output logic [gs*gs-1:0]   matrix_o,
  output logic               frame_valid_o,
  output logic               err_o,
  output logic               overrun_o
);

  localparam int IdxW = (gs > 1) ? $clog2(gs) : 1;
  localparam int CntW = (st > 1) ? $clog2(st) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(st - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] LastRow = IdxW'(gs - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [gs-1:0]   RowOne  = gs'(1);

  typedef enum logic {
    IDLE,
    CAPT
  } state_t;

  // Input stage and stability filter
  logic [gs-1:0]   r_rowQ;
  logic [gs-1:0]   r_colQ;
  logic [CntW-1:0] r_cnt;
  logic            r_taken;

  // Frame assembly
  state_t                  r_state;
  logic [IdxW-1:0]         r_exp;
  logic [gs-1:0][gs-1:0]   r_shadow;

  // Output side
  logic [gs*gs-1:0] r_matrix;
  logic             r_valid;
  logic             r_err;
  logic             r_overrun;

  // Combinational decode
  logic                  w_pinsChanged;
  logic                  w_acc;
  logic                  w_blank;
  logic                  w_oneHot;
  logic [IdxW-1:0]       w_rowIdx;
  logic [IdxW-1:0]       w_expPrev;
  state_t                w_stateNext;
  logic [IdxW-1:0]       w_expNext;
  logic                  w_store;
  logic                  w_publish;
  logic                  w_err;
  logic [gs-1:0][gs-1:0] w_newFrame;

  assign w_pinsChanged = (row_val_i != r_rowQ) || (col_val_i != r_colQ);
  // One accept per stable period: taken blocks re-accepting the same sample.
  assign w_acc         = (r_cnt == CntMax) && !r_taken && e_cap_i;
  assign w_blank       = (r_rowQ == '0);
  assign w_oneHot      = !w_blank && ((r_rowQ & (r_rowQ - RowOne)) == '0);
  assign w_expPrev     = r_exp - IdxOne;

  // Registers the pins every cycle and counts how long they have held still.
  // Any change restarts the count and re-arms the accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rowQ  <= '0;
      r_colQ  <= '0;
      r_cnt   <= '0;
      r_taken <= 1'b0;
    end else begin
      r_rowQ <= row_val_i;
      r_colQ <= col_val_i;
      if (w_pinsChanged) begin
        r_cnt   <= '0;
        r_taken <= 1'b0;
      end else begin
        if (r_cnt != CntMax) begin
          r_cnt <= r_cnt + CntOne;
        end
        if (w_acc) begin
          r_taken <= 1'b1;
        end
      end
    end
  end

  // Index of the set bit; only meaningful when the row is one-hot.
  always_comb begin
    w_rowIdx = '0;
    for (int i = 0; i < gs; i++) begin
      if (r_rowQ[i]) begin
        w_rowIdx = IdxW'(i);
      end
    end
  end

  // Frame as it would be published now: shadow rows plus the final row that
  // is being accepted this cycle.
  always_comb begin
    w_newFrame          = r_shadow;
    w_newFrame[LastRow] = r_colQ;
  end

  // Next-state logic of the row sequencer. A stray non-zero row in IDLE is
  // ignored so capture can lock on mid-stream at the next row 0. Re-accepting
  // the row just stored is a normal display refresh and is ignored.
  always_comb begin
    w_stateNext = r_state;
    w_expNext   = r_exp;
    w_store     = 1'b0;
    w_publish   = 1'b0;
    w_err       = 1'b0;
    if (!e_cap_i) begin
      w_stateNext = IDLE;
    end else if (w_acc && !w_blank) begin
      if (!w_oneHot) begin
        w_err       = 1'b1;
        w_stateNext = IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_rowIdx == '0) begin
              w_store     = 1'b1;
              w_expNext   = IdxOne;
              w_stateNext = CAPT;
            end
          end
          CAPT: begin
            if (w_rowIdx == r_exp && r_exp != LastRow) begin
              w_store   = 1'b1;
              w_expNext = r_exp + IdxOne;
            end else if (w_rowIdx == r_exp) begin
              w_store     = 1'b1;
              w_publish   = 1'b1;
              w_expNext   = '0;
              w_stateNext = IDLE;
            end else if (w_rowIdx == w_expPrev) begin
              w_stateNext = CAPT;
            end else if (w_rowIdx == '0) begin
              w_err     = 1'b1;
              w_store   = 1'b1;
              w_expNext = IdxOne;
            end else begin
              w_err       = 1'b1;
              w_stateNext = IDLE;
            end
          end
          default: w_stateNext = IDLE;
        endcase
      end
    end
  end

  // Sequencer state and the shadow frame under construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_exp    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_stateNext;
      r_exp   <= w_expNext;
      if (w_store) begin
        r_shadow[w_rowIdx] <= r_colQ;
      end
    end
  end

  // Output handshake. A publish may load a new frame whenever the slot is
  // empty or being emptied on this same edge; otherwise it is dropped and the
  // held frame stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_matrix  <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_err     <= w_err;
      r_overrun <= w_publish && r_valid && !frame_ready_i;
      if (w_publish && (!r_valid || frame_ready_i)) begin
        r_matrix <= w_newFrame;
        r_valid  <= 1'b1;
      end else if (r_valid && frame_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign matrix_o      = r_matrix;
  assign frame_valid_o = r_valid;
  assign err_o         = r_err;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture
// Directed scans of the row/column bus into scan_capture (gs=8, st=2).
// Expected frames are queued as they are scanned; a monitor pops and compares
// each frame the DUT hands over, and counts error/overrun pulses.
module tb_scan_capture;

  localparam logic [63:0] FA = 64'h81_42_24_18_3C_5A_A5_C3;
  localparam logic [63:0] FB = 64'h01_23_45_67_89_AB_CD_EF;
  localparam logic [63:0] FC = 64'h10_20_30_40_50_60_70_0F;
  localparam logic [63:0] FD = 64'hF0_E1_D2_C3_B4_A5_96_87;

  logic        clk;
  logic        rstN;
  logic [7:0]  rowVal;
  logic [7:0]  colVal;
  logic        eCap;
  logic        frameReady;
  logic [63:0] matrix;
  logic        frameValid;
  logic        err;
  logic        overrun;

  int          compared;
  int          mismatched;
  int          errExp;
  int          errSeen;
  int          ovrExp;
  int          ovrSeen;
  logic [63:0] frameQ[$];
  logic [63:0] cur;

  scan_capture #(.gs(8), .st(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .row_val_i     (rowVal),
    .col_val_i     (colVal),
    .e_cap_i       (eCap),
    .frame_ready_i (frameReady),
    .matrix_o      (matrix),
    .frame_valid_o (frameValid),
    .err_o         (err),
    .overrun_o     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Drives one bus value and holds it for the given number of rising edges.
  task automatic applyStimulus(input logic [7:0] row, input logic [7:0] col, input int cycles);
    rowVal = row;
    colVal = col;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic scanRows(input logic [63:0] f, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      applyStimulus(8'b1 << r, f[r*8 +: 8], 3);
    end
  endtask

  // Monitor: samples at the falling edge, pops one expected frame per transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (err === 1'b1) errSeen++;
      if (overrun === 1'b1) ovrSeen++;
      if (frameValid === 1'b1 && frameReady === 1'b1) begin
        if (frameQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_frame: got %h, expected no frame", matrix);
        end else begin
          checkOutput("frame", matrix, frameQ.pop_front());
        end
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    errExp     = 0;
    errSeen    = 0;
    ovrExp     = 0;
    ovrSeen    = 0;
    rstN       = 1'b0;
    rowVal     = '0;
    colVal     = '0;
    eCap       = 1'b1;
    frameReady = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_matrix", matrix, 64'h0);
    checkOutput("reset_valid", 64'(frameValid), 64'h0);
    checkOutput("reset_err", 64'(err), 64'h0);
    checkOutput("reset_overrun", 64'(overrun), 64'h0);
    rstN = 1'b1;
    @(posedge clk);
    #2;

    // Plain scan, exact latency and one-cycle valid with ready high
    $display("[TB] plain scan");
    frameQ.push_back(FA);
    scanRows(FA, 0, 6);
    cur    = FA;
    rowVal = 8'h80;
    colVal = cur[63:56];
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("latency_early", 64'(frameValid), 64'h0);
    @(posedge clk);
    #2;
    checkOutput("latency_rise", 64'(frameValid), 64'h1);
    applyStimulus(8'h00, 8'h00, 1);
    checkOutput("valid_one_cycle", 64'(frameValid), 64'h0);
    applyStimulus(8'h00, 8'h00, 3);

    // One-cycle glitches inside each row must not be accepted
    $display("[TB] glitch scan");
    frameQ.push_back(FB);
    cur = FB;
    for (int r = 0; r < 8; r++) begin
      applyStimulus(8'b1 << r, cur[r*8 +: 8], 3);
      applyStimulus(8'b1 << r, 8'hFF, 1);
      applyStimulus(8'b1 << r, cur[r*8 +: 8], 3);
    end
    applyStimulus(8'h00, 8'h00, 4);

    // Row skip 0,1,2,5 is an error, then a clean frame
    $display("[TB] row skip");
    scanRows(FC, 0, 2);
    cur = FC;
    applyStimulus(8'h20, cur[47:40], 3);
    errExp++;
    applyStimulus(8'h00, 8'h00, 3);
    frameQ.push_back(FC);
    scanRows(FC, 0, 7);
    applyStimulus(8'h00, 8'h00, 4);

    // Early row 0 restarts the frame with the new row 0 data
    $display("[TB] early row 0 restart");
    applyStimulus(8'h01, 8'h99, 3);
    scanRows(FC, 1, 2);
    errExp++;
    frameQ.push_back(FC);
    scanRows(FC, 0, 7);
    applyStimulus(8'h00, 8'h00, 4);

    // Consumer stalled: second frame is dropped, first held
    $display("[TB] overrun");
    frameReady = 1'b0;
    frameQ.push_back(FA);
    scanRows(FA, 0, 7);
    applyStimulus(8'h00, 8'h00, 4);
    ovrExp++;
    scanRows(FB, 0, 7);
    applyStimulus(8'h00, 8'h00, 4);
    checkOutput("overrun_hold_matrix", matrix, FA);
    checkOutput("overrun_hold_valid", 64'(frameValid), 64'h1);
    frameReady = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("valid_after_take", 64'(frameValid), 64'h0);
    applyStimulus(8'h00, 8'h00, 2);

    // Publish and transfer on the same edge: new frame replaces the old one
    $display("[TB] publish with transfer");
    frameReady = 1'b0;
    frameQ.push_back(FC);
    scanRows(FC, 0, 7);
    applyStimulus(8'h00, 8'h00, 2);
    frameQ.push_back(FD);
    scanRows(FD, 0, 6);
    cur    = FD;
    rowVal = 8'h80;
    colVal = cur[63:56];
    @(posedge clk);
    @(posedge clk);
    #2;
    frameReady = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("swap_valid", 64'(frameValid), 64'h1);
    checkOutput("swap_matrix", matrix, FD);
    applyStimulus(8'h00, 8'h00, 2);
    checkOutput("swap_drained", 64'(frameValid), 64'h0);

    // Multi-hot row is an error; blanks between rows are legal
    $display("[TB] multi-hot row and blanks");
    scanRows(FA, 0, 1);
    applyStimulus(8'h06, 8'h55, 3);
    errExp++;
    frameQ.push_back(FD);
    cur = FD;
    for (int r = 0; r < 8; r++) begin
      applyStimulus(8'b1 << r, cur[r*8 +: 8], 3);
      applyStimulus(8'h00, 8'hA5, 2);
    end
    applyStimulus(8'h00, 8'h00, 3);

    // Capture disabled mid-frame discards the partial frame
    $display("[TB] capture enable");
    scanRows(FB, 0, 3);
    cur  = FB;
    eCap = 1'b0;
    applyStimulus(8'h10, cur[39:32], 3);
    eCap = 1'b1;
    scanRows(FB, 4, 7);
    applyStimulus(8'h00, 8'h00, 3);
    frameQ.push_back(FB);
    scanRows(FB, 0, 7);
    applyStimulus(8'h00, 8'h00, 4);

    // Asynchronous reset mid-frame while a frame is held
    $display("[TB] mid-frame reset");
    frameReady = 1'b0;
    scanRows(FC, 0, 7);
    applyStimulus(8'h00, 8'h00, 2);
    checkOutput("pre_reset_matrix", matrix, FC);
    scanRows(FA, 0, 4);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_matrix", matrix, 64'h0);
    checkOutput("async_reset_valid", 64'(frameValid), 64'h0);
    checkOutput("async_reset_err", 64'(err), 64'h0);
    checkOutput("async_reset_overrun", 64'(overrun), 64'h0);
    @(posedge clk);
    #2;
    rstN       = 1'b1;
    frameReady = 1'b1;
    cur        = FA;
    applyStimulus(8'h08, cur[31:24], 3);
    applyStimulus(8'h10, cur[39:32], 3);
    frameQ.push_back(FA);
    scanRows(FA, 0, 7);
    applyStimulus(8'h00, 8'h00, 5);

    checkOutput("frames_outstanding", 64'(frameQ.size()), 64'h0);
    checkOutput("err_pulses", 64'(errSeen), 64'(errExp));
    checkOutput("overrun_pulses", 64'(ovrSeen), 64'(ovrExp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
